// File: rtl/noc_inject_buffer.sv
// NoC injection buffer: FWFT flit FIFO with header/tail framing check.
// Optional NOC_INJ_STATS_EN adds packet in/out counters.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`Noc_Data_Width-1:0] in_flit,
  input  logic                       in_is_header,
  input  logic                       in_is_tail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [`Noc_Data_Width-1:0] out_flit,
  output logic                       out_is_header,
  output logic                       out_is_tail,
  output logic [ADDR_W:0]            fifo_count,
  output logic [7:0]                 frame_err_cnt
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]                pkt_in_cnt,
  output logic [15:0]                pkt_out_cnt
`endif
);

  localparam int DW = `Noc_Data_Width;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] RDY_MAX = (ADDR_W+1)'(DEPTH - 3);

  typedef enum logic {EXP_HEAD, IN_PKT} fr_e;

  fr_e               fr_q, fr_d;
  logic              fr_wr, fr_err;
  logic [DW+1:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        err_q, err_d;
  logic              push, pop, full, ovf;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;
  logic [DW+1:0]     head;

  // Framer state register
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) fr_q <= EXP_HEAD;
    else            fr_q <= fr_d;
  end

  // Framer next state: advances only on presented flits
  always_comb begin
    fr_d = fr_q;
    if (in_valid) begin
      unique case (1'b1)
        (fr_q == EXP_HEAD):
          if (in_is_header && !in_is_tail) fr_d = IN_PKT;
        (fr_q == IN_PKT):
          if (!in_is_header && in_is_tail) fr_d = EXP_HEAD;
        default: fr_d = fr_q;
      endcase
    end
  end

  // Framer outputs: write enable and framing error
  always_comb begin
    fr_wr  = 1'b0;
    fr_err = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        (fr_q == EXP_HEAD): begin
          fr_wr  = in_is_header;
          fr_err = !in_is_header;
        end
        (fr_q == IN_PKT): begin
          fr_wr  = 1'b1;
          fr_err = in_is_header;
        end
        default: ;
      endcase
    end
  end

  assign full = (count_q == FULL);
  assign pop  = (count_q != '0) && out_ready;
  assign push = fr_wr && (!full || pop);
  assign ovf  = fr_wr && full && !pop;

  // Occupancy, ready look-ahead and saturating error sum
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // one flit may be on the wire and one more launched on seeing ready
    in_ready_d = (count_d <= RDY_MAX);
    err_inc = {1'b0, fr_err} + {1'b0, ovf};
    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Storage array; no reset, reads are gated by occupancy
  always_ff @(posedge noc_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_flit, in_is_header, in_is_tail};
  end

  // Pointers, count, ready and error counter
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign head      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign out_valid = (count_q != '0);
  assign out_flit      = head[DW+1:2];
  assign out_is_header = head[1];
  assign out_is_tail   = head[0];
  assign in_ready      = in_ready_q;
  assign fifo_count    = count_q;
  assign frame_err_cnt = err_q;

`ifdef NOC_INJ_STATS_EN
  logic [15:0] pin_q, pout_q;

  // Packet counters: accepted tails in, popped tails out
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pin_q  <= '0;
      pout_q <= '0;
    end else begin
      if (push && in_is_tail) pin_q  <= pin_q + 1'b1;
      if (pop && head[0])     pout_q <= pout_q + 1'b1;
    end
  end

  assign pkt_in_cnt  = pin_q;
  assign pkt_out_cnt = pout_q;
`endif

endmodule

// File: tb/tb_noc_inject_buffer.sv
// Bench for noc_inject_buffer: vector table plus scoreboard.
// Covers framing, occupancy/ready, overflow, reset and saturation.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_inject_buffer;

  localparam int DW = `Noc_Data_Width;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_flit;
  logic          in_hdr, in_tail;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_flit;
  logic          out_hdr, out_tail;
  logic [3:0]    cnt;
  logic [7:0]    err;
`ifdef NOC_INJ_STATS_EN
  logic [15:0]   pin, pout;
`endif

  noc_inject_buffer #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .noc_clk       (clk),
    .noc_rst_n     (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flit       (in_flit),
    .in_is_header  (in_hdr),
    .in_is_tail    (in_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_hdr),
    .out_is_tail   (out_tail),
    .fifo_count    (cnt),
    .frame_err_cnt (err)
`ifdef NOC_INJ_STATS_EN
    ,
    .pkt_in_cnt    (pin),
    .pkt_out_cnt   (pout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] f;
    logic          h;
    logic          t;
  } ent_t;

  typedef struct {
    logic       h;
    logic       t;
    logic [7:0] tag;
    logic       wr;
    logic       er;
  } vec_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // drive one cycle; returns 1 time unit after the capturing edge
  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [DW-1:0] f);
    in_valid = v;
    in_hdr   = h;
    in_tail  = t;
    in_flit  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic h, input logic t,
                      input logic [DW-1:0] f, input logic wr);
    ent_t e;
    e.f = f;
    e.h = h;
    e.t = t;
    if (wr) sb.push_back(e);
    drive(1'b1, h, t, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // output monitor: pops scoreboard on each accepted head
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("sb_avail", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          ent_t e;
          e = sb.pop_front();
          chk("out_flit", 64'(out_flit), 64'(e.f));
          chk("out_hdr", 64'(out_hdr), 64'(e.h));
          chk("out_tail", 64'(out_tail), 64'(e.t));
          n_pop++;
        end
      end else if (!out_valid) begin
        chk("empty_zero", 64'({out_flit, out_hdr, out_tail}), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vec [12];
    int   p0, ec;

    vec[0]  = '{1'b0, 1'b0, 8'h10, 1'b0, 1'b1};
    vec[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 8'h13, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 8'h14, 1'b1, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 8'h15, 1'b1, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 8'h16, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 8'h17, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 8'h18, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 8'h19, 1'b0, 1'b1};
    vec[10] = '{1'b1, 1'b0, 8'h1A, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b1, 8'h1B, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_hdr = 1'b0;
    in_tail = 1'b0;
    in_flit = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out", 64'({out_flit, out_hdr, out_tail}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    idle(1);
    chk("first_ready", 64'(in_ready), 64'd1);

    // H,D,T streamed straight through
    out_ready = 1'b1;
    p0 = n_pop;
    send(1'b1, 1'b0, 32'h100, 1'b1);
    send(1'b0, 1'b0, 32'h101, 1'b1);
    send(1'b0, 1'b1, 32'h102, 1'b1);
    idle(3);
    chk("t1_pops", 64'(n_pop - p0), 64'd3);
    chk("t1_err", 64'(err), 64'(exp_err));
    chk("t1_count", 64'(cnt), 64'd0);

    // fill to DEPTH-2 with router stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(i == 0, i == 5, 32'h200 + i, 1'b1);
      chk("t2_count", 64'(cnt), 64'(i + 1));
      chk("t2_ready", 64'(in_ready), 64'((i + 1) <= 5));
    end
    out_ready = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      idle(1);
      chk("t2_drain_cnt", 64'(cnt), 64'(k));
      chk("t2_drain_rdy", 64'(in_ready), 64'd1);
    end

    // overflow when full, then push+pop while full
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(1'b1, 1'b1, 32'h300 + i, 1'b1);
    send(1'b1, 1'b1, 32'h3FF, 1'b0);
    exp_err++;
    chk("full_count", 64'(cnt), 64'(DEPTH));
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("ovf_err", 64'(err), 64'(exp_err));
    out_ready = 1'b1;
    send(1'b1, 1'b1, 32'h310, 1'b1);
    chk("pp_full_cnt", 64'(cnt), 64'(DEPTH));
    chk("pp_full_err", 64'(err), 64'(exp_err));
    idle(DEPTH + 1);
    chk("full_drained", 64'(cnt), 64'd0);

    // framing vector table
    for (int i = 0; i < 12; i++) begin
      send(vec[i].h, vec[i].t, 32'h400 + vec[i].tag, vec[i].wr);
      if (vec[i].er) exp_err++;
      chk("vec_count", 64'(cnt), 64'(vec[i].wr));
      chk("vec_err", 64'(err), 64'(exp_err));
    end
    idle(2);

    // reset in the middle of a packet
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'h500, 1'b1);
    send(1'b0, 1'b0, 32'h501, 1'b1);
    send(1'b0, 1'b0, 32'h502, 1'b1);
    chk("mid_count", 64'(cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_err = 0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    p0 = n_pop;
    send(1'b1, 1'b0, 32'h600, 1'b1);
    send(1'b0, 1'b1, 32'h601, 1'b1);
    idle(3);
    chk("post_rst_pops", 64'(n_pop - p0), 64'd2);
    chk("post_rst_err", 64'(err), 64'd0);

`ifdef NOC_INJ_STATS_EN
    begin
      logic [15:0] a0, b0;
      a0 = pin;
      b0 = pout;
      for (int i = 0; i < 4; i++) begin
        send(1'b1, 1'b0, 32'h700 + 2 * i, 1'b1);
        send(1'b0, 1'b1, 32'h701 + 2 * i, 1'b1);
      end
      idle(3);
      chk("pkt_in_cnt", 64'(16'(pin - a0)), 64'd4);
      chk("pkt_out_cnt", 64'(16'(pout - b0)), 64'd4);
    end
`endif

    // saturate the error counter with orphan flits
    for (int i = 0; i < 260; i++) send(1'b0, 1'b0, 32'h800 + i, 1'b0);
    ec = exp_err + 260;
    exp_err = (ec > 255) ? 255 : ec;
    chk("err_sat", 64'(err), 64'(exp_err));
    send(1'b0, 1'b1, 32'h900, 1'b0);
    chk("err_sat_hold", 64'(err), 64'd255);
    idle(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("end_count", 64'(cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
